stopwatch_tick_counter: RTL and testbench
=========================================

Name: stopwatch_tick_counter

Overview:
- Consumes the 10 ms single-cycle tick from the board clock divider (100 MHz / 1,000,000) and accumulates elapsed time as six BCD digits, MM:SS.CC.
- Implements two-button stopwatch control: start/stop, and lap/clear.
- Feeds the seven-segment display driver.
- The tick is accepted only while timing; the divider free-runs independently.

Parameters:
- HOLD_ON_OVF, 0: 0 = wrap 59:59.99 -> 00:00.00 and set overflow; 1 = saturate at 59:59.99 and set overflow.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle enable pulse, once per 10 ms
- start_stop  in  1  debounced single-cycle button pulse
- lap_clear  in  1  debounced single-cycle button pulse
- disp_bcd  out  24  {M10,M1,S10,S1,C10,C1}, 4 bits each, M10 in the MSBs
- running  out  1  high in RUNNING or LAP
- lap_active  out  1  high in LAP (display frozen)
- overflow  out  1  sticky wrap/saturate flag

Behaviour:
- Reset: on posedge clk with reset high, state = IDLE, count = 0, lap_reg = 0, overflow = 0. Outputs are disp_bcd = 0, running = 0, lap_active = 0. Reset overrides every other input, including mid-run.
- States: IDLE, RUNNING, STOPPED, LAP. All outputs are derived from registers; there is no combinational input-to-output path.
- IDLE:
  - start_stop -> RUNNING.
  - lap_clear -> stays in IDLE, no effect.
- RUNNING:
  - start_stop -> STOPPED.
  - lap_clear -> LAP, and lap_reg <= the count value present in the cycle of the press, i.e. before any coincident tick increment.
- LAP:
  - lap_clear -> RUNNING (display returns to live count).
  - start_stop -> STOPPED; the lap is discarded and the display shows the live count.
- STOPPED:
  - start_stop -> RUNNING (resume without clearing).
  - lap_clear -> IDLE, with count <= 0 and overflow <= 0.
- Simultaneous presses: start_stop has priority and lap_clear is ignored that cycle.
- Counting:
  - Count advances only when tick = 1 and state is RUNNING or LAP. This includes the cycle in which the state is leaving RUNNING/LAP.
  - Count does not advance in the cycle that enters RUNNING from IDLE or STOPPED.
  - Latency: tick at cycle n -> incremented disp_bcd visible after edge n+1.
- Digit chain:
  - C1 0-9, carry to C10 0-9, carry to S1 0-9, carry to S10 0-5, carry to M1 0-9, carry to M10 0-5.
  - Each digit advances only when all lower digits are at their maximum and the tick is enabled.
  - Each digit holds a legal BCD value at all times.
- Terminal count: a tick at 59:59.99.
  - HOLD_ON_OVF = 0: count -> 00:00.00, overflow <= 1, counting continues.
  - HOLD_ON_OVF = 1: count holds at 59:59.99, overflow <= 1, state is unchanged.
  - overflow clears only on reset or on the STOPPED -> IDLE transition.
- Display select: disp_bcd = lap_reg in LAP, otherwise the live count. lap_reg is never cleared except by reset and by STOPPED -> IDLE.
- No handshake back to the divider. A tick arriving in IDLE or STOPPED is dropped; it is not queued.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding constants ST_IDLE, ST_RUNNING, ST_STOPPED, ST_LAP;
  - digit maxima DEC_MAX = 9, SEX_MAX = 5;
  - digit field offsets within disp_bcd.
- One sub-module: bcd_digit_counter.
  - Parameter: MAX.
  - Ports: clk, reset, clr, en, digit[3:0], at_max.
  - Instantiated six times. The carry chain is formed in the parent as en_k = en_{k-1} & at_max_{k-1}.
  - Saturation gating is done in the parent.

Test Plan:
- Basic count: reset, start_stop, 150 ticks spaced 5 cycles apart, start_stop -> disp_bcd = 0x000150, running = 0, state STOPPED; further ticks leave 0x000150 unchanged.
- Lap capture: RUNNING at 00:01.23, lap_clear in the same cycle as a tick -> disp_bcd frozen at 0x000123, lap_active = 1. After 10 more ticks, lap_clear -> disp_bcd = 0x000134, lap_active = 0.
- Clear and resume: STOPPED at 00:02.00.
  - start_stop, then 5 ticks -> 0x000205.
  - start_stop, then lap_clear -> 0x000000, IDLE, overflow = 0.
  - lap_clear in IDLE -> no change.
- Carry boundaries: preload by ticking to 00:59.99, one tick -> 0x010000; from 09:59.99, one tick -> 0x100000.
- Overflow: at 59:59.99, one tick.
  - HOLD_ON_OVF = 0 -> 0x000000, overflow = 1, still counting.
  - HOLD_ON_OVF = 1 -> 0x595999 held, overflow = 1.
  - Simultaneous start_stop + lap_clear in RUNNING -> STOPPED only.
- Reset mid-run: RUNNING in LAP at 00:03.45, reset high for 1 cycle with tick coincident -> all outputs 0, state IDLE, the tick is not counted.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch tick counter: FSM encoding, digit
// maxima and digit field offsets within the BCD display word.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2,
        ST_LAP     = 2'd3
    } state_t;

    localparam logic [3:0] DEC_MAX = 4'd9;
    localparam logic [3:0] SEX_MAX = 4'd5;

    localparam int NUM_DIGITS = 6;
    localparam int DIG_C1  = 0;
    localparam int DIG_C10 = 4;
    localparam int DIG_S1  = 8;
    localparam int DIG_S10 = 12;
    localparam int DIG_M1  = 16;
    localparam int DIG_M10 = 20;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MAX and wraps; at_max feeds the carry chain.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DEC_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] digit,
    output logic       at_max
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (en) begin
            digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign at_max = (digit_q == MAX);

endmodule

// File: rtl/stopwatch_tick_counter.sv
// Two-button stopwatch: MM:SS.CC BCD counter driven by a 10 ms tick, with
// lap freeze, stop/resume/clear and a sticky overflow flag.
module stopwatch_tick_counter
    import stopwatch_pkg::*;
#(
    parameter bit HOLD_ON_OVF = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap_clear,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    state_t      state_q, state_d;
    logic [23:0] lap_q, lap_d;
    logic        ovf_q, ovf_d;

    logic [NUM_DIGITS-1:0] dig_en;
    logic [NUM_DIGITS-1:0] dig_at_max;
    logic [3:0]            dig_c1, dig_c10, dig_s1, dig_s10, dig_m1, dig_m10;
    logic [23:0]           count;

    logic timing;
    logic count_en;
    logic all_max;
    logic terminal;
    logic clr_count;
    logic lap_press;

    assign count = {dig_m10, dig_m1, dig_s10, dig_s1, dig_c10, dig_c1};

    assign timing    = (state_q == ST_RUNNING) || (state_q == ST_LAP);
    assign count_en  = tick && timing;
    assign all_max   = &dig_at_max;
    assign terminal  = count_en && all_max;
    assign clr_count = (state_q == ST_STOPPED) && lap_clear && !start_stop;
    assign lap_press = (state_q == ST_RUNNING) && lap_clear && !start_stop;

    // Saturating mode simply withholds the enable at terminal count.
    assign dig_en[0] = HOLD_ON_OVF ? (count_en && !all_max) : count_en;
    assign dig_en[1] = dig_en[0] && dig_at_max[0];
    assign dig_en[2] = dig_en[1] && dig_at_max[1];
    assign dig_en[3] = dig_en[2] && dig_at_max[2];
    assign dig_en[4] = dig_en[3] && dig_at_max[3];
    assign dig_en[5] = dig_en[4] && dig_at_max[4];

    bcd_digit_counter #(.MAX(DEC_MAX)) u_c1 (
        .clk(clk), .reset(reset), .clr(clr_count), .en(dig_en[0]),
        .digit(dig_c1), .at_max(dig_at_max[0])
    );
    bcd_digit_counter #(.MAX(DEC_MAX)) u_c10 (
        .clk(clk), .reset(reset), .clr(clr_count), .en(dig_en[1]),
        .digit(dig_c10), .at_max(dig_at_max[1])
    );
    bcd_digit_counter #(.MAX(DEC_MAX)) u_s1 (
        .clk(clk), .reset(reset), .clr(clr_count), .en(dig_en[2]),
        .digit(dig_s1), .at_max(dig_at_max[2])
    );
    bcd_digit_counter #(.MAX(SEX_MAX)) u_s10 (
        .clk(clk), .reset(reset), .clr(clr_count), .en(dig_en[3]),
        .digit(dig_s10), .at_max(dig_at_max[3])
    );
    bcd_digit_counter #(.MAX(DEC_MAX)) u_m1 (
        .clk(clk), .reset(reset), .clr(clr_count), .en(dig_en[4]),
        .digit(dig_m1), .at_max(dig_at_max[4])
    );
    bcd_digit_counter #(.MAX(SEX_MAX)) u_m10 (
        .clk(clk), .reset(reset), .clr(clr_count), .en(dig_en[5]),
        .digit(dig_m10), .at_max(dig_at_max[5])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lap_q   <= 24'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
        end
    end

    // start_stop always wins over a coincident lap_clear.
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_stop) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (start_stop) begin
                    state_d = ST_STOPPED;
                end else if (lap_clear) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (start_stop) begin
                    state_d = ST_STOPPED;
                end else if (lap_clear) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_STOPPED: begin
                if (start_stop) begin
                    state_d = ST_RUNNING;
                end else if (lap_clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (lap_press) lap_d = count;
        if (terminal)  ovf_d = 1'b1;
        if (clr_count) begin
            lap_d = 24'd0;
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        disp_bcd   = (state_q == ST_LAP) ? lap_q : count;
        running    = timing;
        lap_active = (state_q == ST_LAP);
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Directed bench for stopwatch_tick_counter, both overflow modes side by side.
module tb_stopwatch_tick_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap_clear = 1'b0;
    logic [23:0] disp0, disp1;
    logic        run0, run1, lap0, lap1, ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_tick_counter #(.HOLD_ON_OVF(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
        .lap_clear(lap_clear), .disp_bcd(disp0), .running(run0),
        .lap_active(lap0), .overflow(ovf0)
    );

    stopwatch_tick_counter #(.HOLD_ON_OVF(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
        .lap_clear(lap_clear), .disp_bcd(disp1), .running(run1),
        .lap_active(lap1), .overflow(ovf1)
    );

    typedef struct packed {
        logic        ss;
        logic        lc;
        logic        tk;
        logic [23:0] disp;
        logic        run;
        logic        lap;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic cmp(input string nm, input logic [23:0] act, input logic [23:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic chk(input string nm, input logic [23:0] e0, input logic [23:0] e1,
                       input logic er, input logic el, input logic eo);
        cmp({nm, " disp0"}, disp0, e0);
        cmp({nm, " disp1"}, disp1, e1);
        cmp({nm, " run0"}, {23'd0, run0}, {23'd0, er});
        cmp({nm, " run1"}, {23'd0, run1}, {23'd0, er});
        cmp({nm, " lap0"}, {23'd0, lap0}, {23'd0, el});
        cmp({nm, " lap1"}, {23'd0, lap1}, {23'd0, el});
        cmp({nm, " ovf0"}, {23'd0, ovf0}, {23'd0, eo});
        cmp({nm, " ovf1"}, {23'd0, ovf1}, {23'd0, eo});
    endtask

    task automatic drive(input logic ss, input logic lc, input logic tk);
        start_stop = ss;
        lap_clear  = lc;
        tick       = tk;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap_clear  = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            for (int j = 1; j < gap; j++) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Jumps both counters to a chosen time so the deep carries stay within budget.
    task automatic preload(input logic [23:0] v);
        @(negedge clk);
        force u_dut0.u_c1.digit_q  = v[3:0];
        force u_dut0.u_c10.digit_q = v[7:4];
        force u_dut0.u_s1.digit_q  = v[11:8];
        force u_dut0.u_s10.digit_q = v[15:12];
        force u_dut0.u_m1.digit_q  = v[19:16];
        force u_dut0.u_m10.digit_q = v[23:20];
        force u_dut1.u_c1.digit_q  = v[3:0];
        force u_dut1.u_c10.digit_q = v[7:4];
        force u_dut1.u_s1.digit_q  = v[11:8];
        force u_dut1.u_s10.digit_q = v[15:12];
        force u_dut1.u_m1.digit_q  = v[19:16];
        force u_dut1.u_m10.digit_q = v[23:20];
        #1;
        release u_dut0.u_c1.digit_q;
        release u_dut0.u_c10.digit_q;
        release u_dut0.u_s1.digit_q;
        release u_dut0.u_s10.digit_q;
        release u_dut0.u_m1.digit_q;
        release u_dut0.u_m10.digit_q;
        release u_dut1.u_c1.digit_q;
        release u_dut1.u_c10.digit_q;
        release u_dut1.u_s1.digit_q;
        release u_dut1.u_s10.digit_q;
        release u_dut1.u_m1.digit_q;
        release u_dut1.u_m10.digit_q;
    endtask

    initial begin
        //            ss    lc    tk    disp          run   lap   ovf
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 24'h000001, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 24'h000002, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 24'h000004, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 24'h000005, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 24'h000005, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();
        chk("reset", 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ss, vecs[i].lc, vecs[i].tk);
            chk($sformatf("vec%0d", i), vecs[i].disp, vecs[i].disp,
                vecs[i].run, vecs[i].lap, vecs[i].ovf);
        end

        // Basic count, then ticks while stopped are dropped
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        ticks(150, 5);
        drive(1'b1, 1'b0, 1'b0);
        chk("basic stop", 24'h000150, 24'h000150, 1'b0, 1'b0, 1'b0);
        ticks(3, 1);
        chk("basic drop", 24'h000150, 24'h000150, 1'b0, 1'b0, 1'b0);

        // Lap capture with coincident tick
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        ticks(123, 1);
        drive(1'b0, 1'b1, 1'b1);
        chk("lap freeze", 24'h000123, 24'h000123, 1'b1, 1'b1, 1'b0);
        ticks(10, 2);
        chk("lap held", 24'h000123, 24'h000123, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        chk("lap release", 24'h000134, 24'h000134, 1'b1, 1'b0, 1'b0);

        // Clear and resume
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        ticks(200, 1);
        drive(1'b1, 1'b0, 1'b0);
        chk("stopped 2.00", 24'h000200, 24'h000200, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        ticks(5, 1);
        chk("resume", 24'h000205, 24'h000205, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        chk("clear", 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        chk("idle lc", 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);

        // Carry boundaries
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        ticks(5999, 1);
        chk("00:59.99", 24'h005999, 24'h005999, 1'b1, 1'b0, 1'b0);
        ticks(1, 1);
        chk("01:00.00", 24'h010000, 24'h010000, 1'b1, 1'b0, 1'b0);
        preload(24'h095999);
        ticks(1, 1);
        chk("10:00.00", 24'h100000, 24'h100000, 1'b1, 1'b0, 1'b0);

        // Terminal count in both modes
        preload(24'h595998);
        ticks(1, 1);
        chk("59:59.99", 24'h595999, 24'h595999, 1'b1, 1'b0, 1'b0);
        ticks(1, 1);
        chk("ovf", 24'h000000, 24'h595999, 1'b1, 1'b0, 1'b1);
        ticks(1, 1);
        chk("ovf after", 24'h000001, 24'h595999, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("both btn", 24'h000001, 24'h595999, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        chk("ovf clear", 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);

        // Reset mid-lap with a coincident tick
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        ticks(345, 1);
        drive(1'b0, 1'b1, 1'b0);
        chk("pre reset lap", 24'h000345, 24'h000345, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick  = 1'b0;
        chk("mid reset", 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);
        ticks(2, 1);
        chk("post reset idle", 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
